imem_uart_loader: RTL and testbench

- Boot-time writer for the instruction memory that the core's fetch/decode path reads.
- Takes a byte stream from the UART receiver, checks the frame, and packs little-endian 32-bit instruction words.
- Writes the words sequentially into the instruction memory write port.
- Holds the core in reset until a frame with a valid checksum has been fully loaded; then releases it.

---
 rtl/loader_pkg.sv | 25 ++
 rtl/word_assembler.sv | 40 ++++
 rtl/imem_uart_loader.sv | 136 +++++++++++++
 tb/tb_imem_uart_loader.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// ============================================================================
// Module  : loader_pkg
// Purpose : Shared types and constants for the UART instruction-memory loader.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package loader_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CNT_HI = 3'd1,
    CNT_LO = 3'd2,
    DATA   = 3'd3,
    CHK    = 3'd4,
    DONE   = 3'd5,
    ERR    = 3'd6
  } state_t;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int         CNT_W     = 16;

endpackage

`default_nettype wire

// File: rtl/word_assembler.sv
// ============================================================================
// Module  : word_assembler
// Purpose : Packs four bytes, first byte lowest, into a 32-bit word.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module word_assembler (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        en,
  input  logic [7:0]  din,
  output logic [31:0] word,
  output logic        word_ready
);

  logic [1:0]  r_lane;
  logic [23:0] r_shift;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lane  <= 2'd0;
      r_shift <= 24'd0;
    end else if (clear) begin
      r_lane  <= 2'd0;
      r_shift <= 24'd0;
    end else if (en) begin
      r_lane  <= r_lane + 2'd1;
      r_shift <= {din, r_shift[23:8]};
    end
  end

  // The fourth byte is inserted on the fly so the word is complete in its own cycle.
  assign word       = {din, r_shift};
  assign word_ready = en && (r_lane == 2'd3);

endmodule

`default_nettype wire

// File: rtl/imem_uart_loader.sv
// ============================================================================
// Module  : imem_uart_loader
// Purpose : Frames UART bytes into instruction words, writes imem, releases core.
//           Optional: LOADER_RELOAD_EN allows a new frame after DONE.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module imem_uart_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W         = 8,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              error
);

  localparam int                IDLE_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W:0]    MAX_WORDS  = (CNT_W + 1)'(2 ** ADDR_W);
  localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(TIMEOUT_CYCLES - 1);

  state_t            r_state, w_next;
  logic [7:0]        r_cnt_hi;
  logic [CNT_W-1:0]  r_n;
  logic [CNT_W-1:0]  r_widx;
  logic [7:0]        r_chk;
  logic [IDLE_W-1:0] r_idle;

  logic [CNT_W-1:0]  w_n;
  logic              w_sync, w_active, w_timeout, w_last_word;
  logic              w_start, w_byte_en, w_done_nx, w_err_nx, w_cpurst_nx;
  logic [31:0]       w_word;
  logic              w_word_ready;

  assign w_n         = {r_cnt_hi, rx_data};
  assign w_sync      = rx_valid && (rx_data == SYNC_BYTE);
  assign w_active    = (r_state == CNT_HI) || (r_state == CNT_LO) ||
                       (r_state == DATA)   || (r_state == CHK);
  assign w_timeout   = w_active && !rx_valid && (r_idle == IDLE_LIMIT);
  assign w_last_word = (r_widx == r_n - 1'b1);

  word_assembler u_asm (
    .clk        (clk),
    .reset      (reset),
    .clear      (w_start),
    .en         (w_byte_en),
    .din        (rx_data),
    .word       (w_word),
    .word_ready (w_word_ready)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:   if (w_sync) w_next = CNT_HI;
      CNT_HI: if (rx_valid) w_next = CNT_LO;
      CNT_LO: if (rx_valid) begin
                if ({1'b0, w_n} > MAX_WORDS) w_next = ERR;
                else if (w_n == '0)          w_next = CHK;
                else                         w_next = DATA;
              end
      DATA:   if (w_word_ready && w_last_word) w_next = CHK;
      CHK:    if (rx_valid) w_next = (rx_data == r_chk) ? DONE : ERR;
      DONE: begin
`ifdef LOADER_RELOAD_EN
              if (w_sync) w_next = CNT_HI;
`endif
            end
      ERR:    if (w_sync) w_next = CNT_HI;
      default: w_next = IDLE;
    endcase
    if (w_timeout) w_next = ERR;
  end

  // Status flags are decoded from the next state so they land in flops with it.
  always_comb begin
    w_start     = (w_next == CNT_HI) &&
                  ((r_state == IDLE) || (r_state == ERR) || (r_state == DONE));
    w_byte_en   = (r_state == DATA) && rx_valid;
    w_done_nx   = (w_next == DONE);
    w_err_nx    = (w_next == ERR);
    w_cpurst_nx = (w_next != DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      imem_we    <= 1'b0;
      imem_waddr <= '0;
      imem_wdata <= 32'd0;
      cpu_reset  <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
      r_cnt_hi   <= 8'd0;
      r_n        <= '0;
      r_widx     <= '0;
      r_chk      <= 8'd0;
      r_idle     <= '0;
    end else begin
      imem_we   <= w_word_ready;
      done      <= w_done_nx;
      error     <= w_err_nx;
      cpu_reset <= w_cpurst_nx;
      if (w_word_ready) begin
        imem_waddr <= r_widx[ADDR_W-1:0];
        imem_wdata <= w_word;
        r_widx     <= r_widx + 1'b1;
      end
      if (r_state == CNT_HI && rx_valid) r_cnt_hi <= rx_data;
      if (r_state == CNT_LO && rx_valid) r_n <= w_n;
      if (w_byte_en) r_chk <= r_chk + rx_data;
      if (w_start) begin
        r_widx <= '0;
        r_chk  <= 8'd0;
      end
      if (!w_active || rx_valid) r_idle <= '0;
      else                       r_idle <= r_idle + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_imem_uart_loader.sv
// ============================================================================
// Module  : tb_imem_uart_loader
// Purpose : Directed self-checking bench for imem_uart_loader.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_imem_uart_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        imem_we;
  logic [7:0]  imem_waddr;
  logic [31:0] imem_wdata;
  logic        cpu_reset, done, error;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]  wq_addr[$];
  logic [31:0] wq_data[$];

  imem_uart_loader #(.ADDR_W(8), .TIMEOUT_CYCLES(50)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .imem_we    (imem_we),
    .imem_waddr (imem_waddr),
    .imem_wdata (imem_wdata),
    .cpu_reset  (cpu_reset),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wq_addr.push_back(imem_waddr);
      wq_data.push_back(imem_wdata);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    rx_valid = 1'b0;
    reset    = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    wq_addr.delete();
    wq_data.delete();
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    vectors++; if (imem_we !== 1'b0) begin miscompares++; $display("FAIL reset_we: got %b want 0", imem_we); end
    vectors++; if (imem_waddr !== 8'd0) begin miscompares++; $display("FAIL reset_waddr: got %h want 00", imem_waddr); end
    vectors++; if (imem_wdata !== 32'd0) begin miscompares++; $display("FAIL reset_wdata: got %h want 0", imem_wdata); end
    vectors++; if (cpu_reset !== 1'b1) begin miscompares++; $display("FAIL reset_cpu_reset: got %b want 1", cpu_reset); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", done); end
    vectors++; if (error !== 1'b0) begin miscompares++; $display("FAIL reset_error: got %b want 0", error); end
  endtask

  task automatic test_good_frame();
    logic [7:0] pre[9] = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h02, 8'h13, 8'h00, 8'h50, 8'h00};
    logic [7:0] post[4] = '{8'h93, 8'h00, 8'h10, 8'h00};
    do_reset();
    foreach (pre[i]) send_byte(pre[i]);
    vectors++; if (imem_we !== 1'b1) begin miscompares++; $display("FAIL good_we_pulse: got %b want 1", imem_we); end
    vectors++; if (imem_waddr !== 8'd0) begin miscompares++; $display("FAIL good_waddr0_live: got %h want 00", imem_waddr); end
    vectors++; if (imem_wdata !== 32'h00500013) begin miscompares++; $display("FAIL good_wdata0_live: got %h want 00500013", imem_wdata); end
    @(posedge clk); #1;
    vectors++; if (imem_we !== 1'b0) begin miscompares++; $display("FAIL good_we_width: got %b want 0", imem_we); end
    foreach (post[i]) send_byte(post[i]);
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL good_done_early: got %b want 0", done); end
    send_byte(8'h06);
    @(negedge clk);
    vectors++; if (wq_addr.size() !== 2) begin miscompares++; $display("FAIL good_write_count: got %0d want 2", wq_addr.size()); end
    if (wq_addr.size() >= 2) begin
      vectors++; if (wq_addr[1] !== 8'd1) begin miscompares++; $display("FAIL good_waddr1: got %h want 01", wq_addr[1]); end
      vectors++; if (wq_data[1] !== 32'h00100093) begin miscompares++; $display("FAIL good_wdata1: got %h want 00100093", wq_data[1]); end
    end
    vectors++; if (cpu_reset !== 1'b0) begin miscompares++; $display("FAIL good_cpu_reset: got %b want 0", cpu_reset); end
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL good_done: got %b want 1", done); end
    vectors++; if (error !== 1'b0) begin miscompares++; $display("FAIL good_error: got %b want 0", error); end
  endtask

  task automatic test_bad_chk();
    logic [7:0] fr[14] = '{8'hA5, 8'h00, 8'h02, 8'h13, 8'h00, 8'h50, 8'h00,
                           8'h93, 8'h00, 8'h10, 8'h00, 8'h07, 8'h00, 8'h00};
    do_reset();
    for (int i = 0; i < 12; i++) send_byte(fr[i]);
    @(negedge clk);
    vectors++; if (error !== 1'b1) begin miscompares++; $display("FAIL badchk_error: got %b want 1", error); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL badchk_done: got %b want 0", done); end
    vectors++; if (cpu_reset !== 1'b1) begin miscompares++; $display("FAIL badchk_cpu_reset: got %b want 1", cpu_reset); end
    wq_addr.delete();
    wq_data.delete();
    fr[11] = 8'h06;
    for (int i = 0; i < 12; i++) send_byte(fr[i]);
    @(negedge clk);
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL retry_done: got %b want 1", done); end
    vectors++; if (error !== 1'b0) begin miscompares++; $display("FAIL retry_error: got %b want 0", error); end
    vectors++; if (wq_addr.size() !== 2) begin miscompares++; $display("FAIL retry_write_count: got %0d want 2", wq_addr.size()); end
    if (wq_addr.size() >= 1) begin
      vectors++; if (wq_addr[0] !== 8'd0) begin miscompares++; $display("FAIL retry_waddr0: got %h want 00", wq_addr[0]); end
    end
  endtask

  task automatic test_timeout();
    logic [7:0] fr[6] = '{8'hA5, 8'h00, 8'h01, 8'h13, 8'h00, 8'h50};
    do_reset();
    foreach (fr[i]) send_byte(fr[i]);
    repeat (49) @(posedge clk);
    #1;
    vectors++; if (error !== 1'b0) begin miscompares++; $display("FAIL timeout_early: got %b want 0 after 49 idle", error); end
    @(posedge clk); #1;
    vectors++; if (error !== 1'b1) begin miscompares++; $display("FAIL timeout_error: got %b want 1 after 50 idle", error); end
    vectors++; if (cpu_reset !== 1'b1) begin miscompares++; $display("FAIL timeout_cpu_reset: got %b want 1", cpu_reset); end
    vectors++; if (wq_addr.size() !== 0) begin miscompares++; $display("FAIL timeout_writes: got %0d want 0", wq_addr.size()); end
  endtask

  task automatic test_oversize();
    do_reset();
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h01);
    vectors++; if (error !== 1'b1) begin miscompares++; $display("FAIL oversize_error: got %b want 1", error); end
    for (int i = 0; i < 4; i++) send_byte(8'h00);
    @(negedge clk);
    vectors++; if (wq_addr.size() !== 0) begin miscompares++; $display("FAIL oversize_writes: got %0d want 0", wq_addr.size()); end
    vectors++; if (error !== 1'b1) begin miscompares++; $display("FAIL oversize_hold: got %b want 1", error); end
  endtask

  task automatic test_zero_words();
    do_reset();
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    @(negedge clk);
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL zero_done: got %b want 1", done); end
    vectors++; if (cpu_reset !== 1'b0) begin miscompares++; $display("FAIL zero_cpu_reset: got %b want 0", cpu_reset); end
    vectors++; if (wq_addr.size() !== 0) begin miscompares++; $display("FAIL zero_writes: got %0d want 0", wq_addr.size()); end
  endtask

  task automatic test_mid_reset();
    logic [7:0] fr[9]  = '{8'hA5, 8'h00, 8'h02, 8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00};
    logic [7:0] fr2[8] = '{8'hA5, 8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h0E};
    do_reset();
    foreach (fr[i]) send_byte(fr[i]);
    reset = 1'b1;
    #1;
    vectors++; if (imem_waddr !== 8'd0) begin miscompares++; $display("FAIL midrst_waddr: got %h want 00", imem_waddr); end
    vectors++; if (imem_wdata !== 32'd0) begin miscompares++; $display("FAIL midrst_wdata: got %h want 0", imem_wdata); end
    vectors++; if (cpu_reset !== 1'b1) begin miscompares++; $display("FAIL midrst_cpu_reset: got %b want 1", cpu_reset); end
    do_reset();
    foreach (fr2[i]) send_byte(fr2[i]);
    @(negedge clk);
    vectors++; if (wq_addr.size() !== 1) begin miscompares++; $display("FAIL midrst_write_count: got %0d want 1", wq_addr.size()); end
    if (wq_addr.size() >= 1) begin
      vectors++; if (wq_addr[0] !== 8'd0) begin miscompares++; $display("FAIL midrst_waddr0: got %h want 00", wq_addr[0]); end
      vectors++; if (wq_data[0] !== 32'hDDCCBBAA) begin miscompares++; $display("FAIL midrst_wdata0: got %h want DDCCBBAA", wq_data[0]); end
    end
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL midrst_done: got %b want 1", done); end
  endtask

  task automatic test_reload();
    logic [7:0] fr[6] = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
    logic       exp_cpu_reset, exp_done;
    int         exp_writes;
`ifdef LOADER_RELOAD_EN
    exp_cpu_reset = 1'b1; exp_done = 1'b0; exp_writes = 1;
`else
    exp_cpu_reset = 1'b0; exp_done = 1'b1; exp_writes = 0;
`endif
    test_zero_words();
    wq_addr.delete();
    wq_data.delete();
    send_byte(8'hA5);
    vectors++; if (cpu_reset !== exp_cpu_reset) begin miscompares++; $display("FAIL reload_cpu_reset: got %b want %b", cpu_reset, exp_cpu_reset); end
    vectors++; if (done !== exp_done) begin miscompares++; $display("FAIL reload_done: got %b want %b", done, exp_done); end
    foreach (fr[i]) send_byte(fr[i]);
    send_byte(8'hAA);
    @(negedge clk);
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL reload_final_done: got %b want 1", done); end
    vectors++; if (wq_addr.size() !== exp_writes) begin miscompares++; $display("FAIL reload_writes: got %0d want %0d", wq_addr.size(), exp_writes); end
    if (wq_data.size() >= 1) begin
      vectors++; if (wq_data[0] !== 32'h44332211) begin miscompares++; $display("FAIL reload_wdata: got %h want 44332211", wq_data[0]); end
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_chk();
    test_timeout();
    test_oversize();
    test_zero_words();
    test_mid_reset();
    test_reload();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
